// File: rtl/hella_cache_master_engine.sv
// Multi-outstanding HellaCache master: slot-tagged load/store issue, s2 nack replay,
// out-of-order completion through a backpressurable response port.
module hella_cache_master_engine #(
    parameter int NUM_ADDR_BITS   = 40,
    parameter int NUM_DATA_BITS   = 64,
    parameter int NUM_TAG_BITS    = 7,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_BITS         = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_write_i,
    input  logic [ID_BITS-1:0]           cmd_id_i,
    input  logic [NUM_ADDR_BITS-1:0]     cmd_addr_i,
    input  logic [2:0]                   cmd_typ_i,
    input  logic [NUM_DATA_BITS-1:0]     cmd_data_i,
    input  logic [NUM_DATA_BITS/8-1:0]   cmd_mask_i,
    output logic                         req_valid_o,
    input  logic                         req_ready_i,
    output logic [NUM_ADDR_BITS-1:0]     req_addr_o,
    output logic [NUM_TAG_BITS-1:0]      req_tag_o,
    output logic [4:0]                   req_cmd_o,
    output logic [2:0]                   req_typ_o,
    output logic [NUM_DATA_BITS-1:0]     s1_data_o,
    output logic [NUM_DATA_BITS/8-1:0]   s1_mask_o,
    output logic                         s1_kill_o,
    input  logic                         s2_nack_i,
    input  logic                         resp_valid_i,
    input  logic [NUM_TAG_BITS-1:0]      resp_tag_i,
    input  logic [NUM_DATA_BITS-1:0]     resp_data_i,
    input  logic                         resp_has_data_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_BITS-1:0]           rsp_id_o,
    output logic                         rsp_write_o,
    output logic [NUM_DATA_BITS-1:0]     rsp_data_o,
    output logic [15:0]                  nack_count_o,
    output logic                         err_unexp_tag_o
);

    localparam int MASK_BITS = NUM_DATA_BITS / 8;
    localparam int SLOT_BITS = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [4:0] CMD_LOAD  = 5'h00;
    localparam logic [4:0] CMD_STORE = 5'h01;

    typedef enum logic [2:0] {
        SLOT_FREE,
        SLOT_ISSUE,
        SLOT_S1,
        SLOT_S2,
        SLOT_WAIT_RSP,
        SLOT_DONE
    } slot_state_e;

    slot_state_e                state_q  [MAX_OUTSTANDING];
    slot_state_e                state_d  [MAX_OUTSTANDING];
    logic                       write_q  [MAX_OUTSTANDING];
    logic [ID_BITS-1:0]         id_q     [MAX_OUTSTANDING];
    logic [NUM_ADDR_BITS-1:0]   addr_q   [MAX_OUTSTANDING];
    logic [2:0]                 typ_q    [MAX_OUTSTANDING];
    logic [NUM_DATA_BITS-1:0]   data_q   [MAX_OUTSTANDING];
    logic [MASK_BITS-1:0]       mask_q   [MAX_OUTSTANDING];

    logic [MAX_OUTSTANDING-1:0] free_vec, issue_vec, s2_vec, wait_vec, done_vec;
    logic [MAX_OUTSTANDING-1:0] resp_sel_vec, capture_vec, req_cand_vec;
    logic [SLOT_BITS-1:0]       alloc_idx, rsp_idx, cand_idx;
    logic                       cmd_ready, cmd_fire, req_fire, rsp_valid, rsp_fire;
    logic                       resp_hit, resp_in_range;

    logic                       req_valid_q, req_valid_d;
    logic [SLOT_BITS-1:0]       req_slot_q, req_slot_d;
    logic [NUM_ADDR_BITS-1:0]   req_addr_q, req_addr_d;
    logic                       req_write_q, req_write_d;
    logic [2:0]                 req_typ_q, req_typ_d;
    logic [NUM_DATA_BITS-1:0]   s1_data_q, s1_data_d;
    logic [MASK_BITS-1:0]       s1_mask_q, s1_mask_d;
    logic [15:0]                nack_count_q, nack_count_d;
    logic                       err_q, err_d;

    assign resp_hit      = resp_valid_i && resp_has_data_i;
    assign resp_in_range = {{(32-NUM_TAG_BITS){1'b0}}, resp_tag_i} < 32'(MAX_OUTSTANDING);

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            free_vec[i]     = (state_q[i] == SLOT_FREE);
            issue_vec[i]    = (state_q[i] == SLOT_ISSUE);
            s2_vec[i]       = (state_q[i] == SLOT_S2);
            wait_vec[i]     = (state_q[i] == SLOT_WAIT_RSP);
            done_vec[i]     = (state_q[i] == SLOT_DONE);
            resp_sel_vec[i] = resp_in_range && (resp_tag_i == NUM_TAG_BITS'(i));
        end
    end

    assign cmd_ready = |free_vec;
    assign cmd_fire  = cmd_valid_i && cmd_ready;
    assign req_fire  = req_valid_q && req_ready_i;
    assign rsp_valid = |done_vec;
    assign rsp_fire  = rsp_valid && rsp_ready_i;

    // A fresh command competes for the request port in its accept cycle.
    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            req_cand_vec[i] = (issue_vec[i] && !(req_fire && req_slot_q == SLOT_BITS'(i)))
                            || (cmd_fire && alloc_idx == SLOT_BITS'(i));
        end
    end

    always_comb begin
        alloc_idx = '0;
        rsp_idx   = '0;
        cand_idx  = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (free_vec[i])     alloc_idx = SLOT_BITS'(i);
            if (done_vec[i])     rsp_idx   = SLOT_BITS'(i);
            if (req_cand_vec[i]) cand_idx  = SLOT_BITS'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            state_d[i]     = state_q[i];
            capture_vec[i] = 1'b0;
            case (state_q[i])
                SLOT_FREE:
                    if (cmd_fire && alloc_idx == SLOT_BITS'(i)) state_d[i] = SLOT_ISSUE;
                SLOT_ISSUE:
                    if (req_fire && req_slot_q == SLOT_BITS'(i)) state_d[i] = SLOT_S1;
                SLOT_S1:
                    state_d[i] = SLOT_S2;
                SLOT_S2: begin
                    if (s2_nack_i) begin
                        state_d[i] = SLOT_ISSUE;
                    end else if (write_q[i]) begin
                        state_d[i] = SLOT_DONE;
                    end else if (resp_hit && resp_sel_vec[i]) begin
                        state_d[i]     = SLOT_DONE;
                        capture_vec[i] = 1'b1;
                    end else begin
                        state_d[i] = SLOT_WAIT_RSP;
                    end
                end
                SLOT_WAIT_RSP:
                    if (resp_hit && resp_sel_vec[i]) begin
                        state_d[i]     = SLOT_DONE;
                        capture_vec[i] = 1'b1;
                    end
                SLOT_DONE:
                    if (rsp_fire && rsp_idx == SLOT_BITS'(i)) state_d[i] = SLOT_FREE;
                default:
                    state_d[i] = SLOT_FREE;
            endcase
        end
    end

    always_comb begin
        req_valid_d  = req_valid_q;
        req_slot_d   = req_slot_q;
        req_addr_d   = req_addr_q;
        req_write_d  = req_write_q;
        req_typ_d    = req_typ_q;
        if (!req_valid_q || req_fire) begin
            req_valid_d = |req_cand_vec;
            if (|req_cand_vec) begin
                req_slot_d = cand_idx;
                if (cmd_fire && cand_idx == alloc_idx) begin
                    req_addr_d  = cmd_addr_i;
                    req_write_d = cmd_write_i;
                    req_typ_d   = cmd_typ_i;
                end else begin
                    req_addr_d  = addr_q[cand_idx];
                    req_write_d = write_q[cand_idx];
                    req_typ_d   = typ_q[cand_idx];
                end
            end
        end
        s1_data_d    = req_fire ? data_q[req_slot_q] : '0;
        s1_mask_d    = req_fire ? mask_q[req_slot_q] : '0;
        nack_count_d = nack_count_q;
        if ((|s2_vec) && s2_nack_i && nack_count_q != 16'hFFFF)
            nack_count_d = nack_count_q + 16'd1;
        // Only slots in S2/WAIT_RSP may legitimately receive data.
        err_d = err_q | (resp_hit && !(|(resp_sel_vec & (s2_vec | wait_vec))));
    end

    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    state_q[gi] <= SLOT_FREE;
                    write_q[gi] <= 1'b0;
                    id_q[gi]    <= '0;
                    addr_q[gi]  <= '0;
                    typ_q[gi]   <= '0;
                    data_q[gi]  <= '0;
                    mask_q[gi]  <= '0;
                end else begin
                    state_q[gi] <= state_d[gi];
                    if (cmd_fire && alloc_idx == SLOT_BITS'(gi)) begin
                        write_q[gi] <= cmd_write_i;
                        id_q[gi]    <= cmd_id_i;
                        addr_q[gi]  <= cmd_addr_i;
                        typ_q[gi]   <= cmd_typ_i;
                        data_q[gi]  <= cmd_data_i;
                        mask_q[gi]  <= cmd_mask_i;
                    end else if (capture_vec[gi]) begin
                        data_q[gi]  <= resp_data_i;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_valid_q  <= 1'b0;
            req_slot_q   <= '0;
            req_addr_q   <= '0;
            req_write_q  <= 1'b0;
            req_typ_q    <= '0;
            s1_data_q    <= '0;
            s1_mask_q    <= '0;
            nack_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            req_valid_q  <= req_valid_d;
            req_slot_q   <= req_slot_d;
            req_addr_q   <= req_addr_d;
            req_write_q  <= req_write_d;
            req_typ_q    <= req_typ_d;
            s1_data_q    <= s1_data_d;
            s1_mask_q    <= s1_mask_d;
            nack_count_q <= nack_count_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready_o     = cmd_ready;
    assign req_valid_o     = req_valid_q;
    assign req_addr_o      = req_addr_q;
    assign req_tag_o       = NUM_TAG_BITS'(req_slot_q);
    assign req_cmd_o       = req_write_q ? CMD_STORE : CMD_LOAD;
    assign req_typ_o       = req_typ_q;
    assign s1_data_o       = s1_data_q;
    assign s1_mask_o       = s1_mask_q;
    assign s1_kill_o       = 1'b0;
    // Valid never drops before rsp_ready; the payload tracks the lowest DONE slot.
    assign rsp_valid_o     = rsp_valid;
    assign rsp_id_o        = rsp_valid ? id_q[rsp_idx] : '0;
    assign rsp_write_o     = rsp_valid && write_q[rsp_idx];
    assign rsp_data_o      = (rsp_valid && !write_q[rsp_idx]) ? data_q[rsp_idx] : '0;
    assign nack_count_o    = nack_count_q;
    assign err_unexp_tag_o = err_q;

endmodule

// File: tb/tb_hella_cache_master_engine.sv
// Randomized bench for hella_cache_master_engine: acts as core and cache, and checks
// every cycle against a transaction-level slot model.
module tb_hella_cache_master_engine;

    localparam int SLOTS = 4;
    localparam int M_FREE = 0, M_PEND = 1, M_FLIGHT = 2, M_WAIT = 3, M_DONE = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [39:0] cmd_addr;
    logic [2:0]  cmd_typ;
    logic [63:0] cmd_data;
    logic [7:0]  cmd_mask;
    logic        req_valid, req_ready;
    logic [39:0] req_addr;
    logic [6:0]  req_tag;
    logic [4:0]  req_cmd;
    logic [2:0]  req_typ;
    logic [63:0] s1_data;
    logic [7:0]  s1_mask;
    logic        s1_kill, s2_nack;
    logic        resp_valid, resp_has_data;
    logic [6:0]  resp_tag;
    logic [63:0] resp_data;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [3:0]  rsp_id;
    logic [63:0] rsp_data;
    logic [15:0] nack_count;
    logic        err_unexp_tag;

    always #5 clock = ~clock;

    hella_cache_master_engine #(
        .NUM_ADDR_BITS(40), .NUM_DATA_BITS(64), .NUM_TAG_BITS(7),
        .MAX_OUTSTANDING(SLOTS), .ID_BITS(4)
    ) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_typ_i(cmd_typ),
        .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
        .req_tag_o(req_tag), .req_cmd_o(req_cmd), .req_typ_o(req_typ),
        .s1_data_o(s1_data), .s1_mask_o(s1_mask), .s1_kill_o(s1_kill),
        .s2_nack_i(s2_nack),
        .resp_valid_i(resp_valid), .resp_tag_i(resp_tag), .resp_data_i(resp_data),
        .resp_has_data_i(resp_has_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_write_o(rsp_write), .rsp_data_o(rsp_data),
        .nack_count_o(nack_count), .err_unexp_tag_o(err_unexp_tag)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one entry per slot, plus the tags fired 1 and 2 cycles ago.
    int          m_state [SLOTS];
    logic        m_write [SLOTS];
    logic [3:0]  m_id    [SLOTS];
    logic [39:0] m_addr  [SLOTS];
    logic [2:0]  m_typ   [SLOTS];
    logic [63:0] m_data  [SLOTS];
    logic [7:0]  m_mask  [SLOTS];
    logic [63:0] m_rdata [SLOTS];
    int          m_nacks;
    logic        m_err;
    int          p1_tag, p2_tag;
    logic        hold_prev;
    logic [6:0]  prev_tag;
    logic [39:0] prev_addr;
    logic        saw_full;
    int          completions;

    int cmd_pct, rreq_pct, rsp_pct, nack_pct;
    int force_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_all_free();
        for (int i = 0; i < SLOTS; i++)
            if (m_state[i] != M_FREE) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_state[i] = M_FREE;
        m_nacks   = 0;
        m_err     = 1'b0;
        p1_tag    = -1;
        p2_tag    = -1;
        hold_prev = 1'b0;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = '0; cmd_addr = '0; cmd_typ = '0;
        cmd_data = '0; cmd_mask = '0; req_ready = 0; s2_nack = 0;
        resp_valid = 0; resp_tag = '0; resp_data = '0; resp_has_data = 0; rsp_ready = 0;
    endtask

    // Called at a negedge: check outputs, drive this cycle's inputs, advance the model.
    task automatic step();
        logic any_free;
        int   low_done, target, alloc, rt;
        int   waits[$];
        logic cf, rf, sf;
        any_free = 1'b0;
        low_done = -1;
        alloc    = -1;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_state[i] == M_FREE) begin
                any_free = 1'b1;
                if (alloc < 0) alloc = i;
            end
            if (m_state[i] == M_DONE && low_done < 0) low_done = i;
        end
        if (!any_free) saw_full = 1'b1;
        check("cmd_ready", 64'(cmd_ready), 64'(any_free));
        check("rsp_valid", 64'(rsp_valid), 64'(low_done >= 0));
        if (rsp_valid && low_done >= 0) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id[low_done]));
            check("rsp_write", 64'(rsp_write), 64'(m_write[low_done]));
            check("rsp_data", rsp_data, m_rdata[low_done]);
        end
        check("nack_count", 64'(nack_count), 64'(m_nacks));
        check("err_unexp_tag", 64'(err_unexp_tag), 64'(m_err));
        check("s1_kill", 64'(s1_kill), 64'd0);
        if (p1_tag >= 0 && m_write[p1_tag]) begin
            check("s1_data", s1_data, m_data[p1_tag]);
            check("s1_mask", 64'(s1_mask), 64'(m_mask[p1_tag]));
        end else if (p1_tag < 0) begin
            check("s1_data_idle", s1_data, 64'd0);
        end
        if (hold_prev) begin
            check("req_hold_valid", 64'(req_valid), 64'd1);
            check("req_hold_tag", 64'(req_tag), 64'(prev_tag));
            check("req_hold_addr", 64'(req_addr), 64'(prev_addr));
        end
        if (req_valid) begin
            rt = int'(req_tag);
            check("req_tag_range", 64'(rt < SLOTS), 64'd1);
            if (rt < SLOTS) begin
                check("req_slot_pending", 64'(m_state[rt]), 64'(M_PEND));
                check("req_addr", 64'(req_addr), 64'(m_addr[rt]));
                check("req_cmd", 64'(req_cmd), m_write[rt] ? 64'h1 : 64'h0);
                check("req_typ", 64'(req_typ), 64'(m_typ[rt]));
            end
        end

        cmd_valid = ($urandom % 100) < cmd_pct;
        cmd_write = 1'($urandom);
        cmd_id    = 4'($urandom);
        cmd_addr  = {8'($urandom), $urandom};
        cmd_typ   = 3'($urandom);
        cmd_data  = {$urandom, $urandom};
        cmd_mask  = 8'($urandom);
        req_ready = ($urandom % 100) < rreq_pct;
        rsp_ready = ($urandom % 100) < rsp_pct;
        s2_nack   = (p2_tag >= 0) && (($urandom % 100) < nack_pct);
        resp_valid = 0; resp_has_data = 0; resp_tag = '0; resp_data = '0;
        target = -1;
        if (force_tag >= 0) begin
            resp_valid = 1; resp_has_data = 1; resp_tag = 7'(force_tag); resp_data = {$urandom, $urandom};
        end else if (p2_tag >= 0 && !m_write[p2_tag] && ($urandom % 3) == 0) begin
            target = p2_tag;
        end else begin
            for (int i = 0; i < SLOTS; i++) if (m_state[i] == M_WAIT) waits.push_back(i);
            if (waits.size() > 0 && ($urandom % 2) == 1)
                target = waits[$urandom_range(0, waits.size() - 1)];
            else if (($urandom % 5) == 0) begin
                resp_valid = 1; resp_has_data = 0; resp_tag = 7'($urandom); resp_data = {$urandom, $urandom};
            end
        end
        if (target >= 0) begin
            resp_valid = 1; resp_has_data = 1; resp_tag = 7'(target); resp_data = {$urandom, $urandom};
        end

        cf = cmd_valid && cmd_ready;
        rf = req_valid && req_ready;
        sf = rsp_valid && rsp_ready;
        hold_prev = req_valid && !req_ready;
        prev_tag  = req_tag;
        prev_addr = req_addr;

        if (sf && low_done >= 0) begin
            m_state[low_done] = M_FREE;
            completions++;
        end
        if (p2_tag >= 0) begin
            if (s2_nack) begin
                m_state[p2_tag] = M_PEND;
                if (m_nacks < 65535) m_nacks++;
            end else if (m_write[p2_tag]) begin
                m_state[p2_tag] = M_DONE;
                m_rdata[p2_tag] = 64'd0;
            end else if (target == p2_tag) begin
                m_state[p2_tag] = M_DONE;
                m_rdata[p2_tag] = resp_data;
            end else begin
                m_state[p2_tag] = M_WAIT;
            end
        end
        if (target >= 0 && target != p2_tag) begin
            m_state[target] = M_DONE;
            m_rdata[target] = resp_data;
        end
        if (force_tag >= 0) m_err = 1'b1;
        p2_tag = p1_tag;
        p1_tag = -1;
        if (rf && int'(req_tag) < SLOTS) begin
            m_state[int'(req_tag)] = M_FLIGHT;
            p1_tag = int'(req_tag);
        end
        if (cf && alloc >= 0) begin
            m_state[alloc] = M_PEND;
            m_write[alloc] = cmd_write;
            m_id[alloc]    = cmd_id;
            m_addr[alloc]  = cmd_addr;
            m_typ[alloc]   = cmd_typ;
            m_data[alloc]  = cmd_data;
            m_mask[alloc]  = cmd_mask;
        end
        @(negedge clock);
    endtask

    task automatic run(input int n, input int c, input int rq, input int rs, input int nk);
        cmd_pct = c; rreq_pct = rq; rsp_pct = rs; nack_pct = nk;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_nack_count"}, 64'(nack_count), 64'd0);
        check({tag, "_err"}, 64'(err_unexp_tag), 64'd0);
        check({tag, "_s1_data"}, s1_data, 64'd0);
        check({tag, "_s1_kill"}, 64'(s1_kill), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        force_tag   = -1;
        saw_full    = 1'b0;
        completions = 0;
        reset_n     = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run(1500, 50, 70, 60, 20);
        run(60, 80, 80, 0, 10);
        check("full_reached", 64'(saw_full), 64'd1);
        run(200, 40, 70, 100, 15);

        force_tag = 5;
        step();
        force_tag = -1;
        run(200, 50, 60, 60, 20);
        check("err_sticky", 64'(err_unexp_tag), 64'd1);

        // Build up in-flight work, then reset asynchronously mid-cycle.
        run(12, 100, 70, 0, 10);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        idle_inputs();
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cmd_pct = 0; rreq_pct = 0; rsp_pct = 0; nack_pct = 0;
        force_tag = 0;
        step();
        force_tag = -1;
        run(300, 50, 70, 60, 20);

        cmd_pct = 0; rreq_pct = 100; rsp_pct = 100; nack_pct = 0;
        for (int k = 0; k < 300 && !model_all_free(); k++) step();
        check("drain_all_free", 64'(model_all_free()), 64'd1);
        check("completions_seen", 64'(completions > 100), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
